// File: rtl/camera_cfg_interface.sv
// SCCB (OV7670-style) register loader: walks an internal {reg,val} table and
// emits one 3-phase write per entry on open-drain SCL/SDA.
module camera_cfg_interface #(
  parameter int          T_CLK    = 13,
  parameter int          SCL_KHZ  = 100,
  parameter logic [7:0]  DEV_ADDR = 8'h42
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_done,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda
);

  // state   | meaning
  // S_IDLE  | lines released, waiting for an i_start rising edge
  // S_LOAD  | decode ROM entry at idx (end, 10 ms wait, or write)
  // S_START | SDA low with SCL released for Q cycles
  // S_BITS  | 27 bits (3 bytes + ACK slots), 4 quarter phases each
  // S_STOP  | SCL low/SDA low, then SCL released, then SDA released
  // S_GAP   | 4Q cycles of idle bus between transactions
  // S_DELAY | 10 ms wait with no bus activity
  // S_DONE  | o_done high, lines released, restart on i_start edge
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  localparam int Q       = (250000 + SCL_KHZ * T_CLK - 1) / (SCL_KHZ * T_CLK);
  localparam int DLY     = (10000000 + T_CLK - 1) / T_CLK;
  localparam int CNT_MAX = (DLY > 4 * Q) ? DLY : 4 * Q;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] Q_LD   = CNT_W'(Q - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(4 * Q - 1);
  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DLY - 1);

  localparam logic [15:0] ENT_END  = 16'hFFFF;
  localparam logic [15:0] ENT_WAIT = 16'hFFF0;

  function automatic logic [15:0] rom_entry(input logic [3:0] a);
    case (a)
      4'd0:    rom_entry = 16'h1280;
      4'd1:    rom_entry = 16'hFFF0;
      4'd2:    rom_entry = 16'h1204;
      4'd3:    rom_entry = 16'h1180;
      4'd4:    rom_entry = 16'h0C00;
      4'd5:    rom_entry = 16'h3E00;
      4'd6:    rom_entry = 16'h40D0;
      4'd7:    rom_entry = 16'h3A04;
      4'd8:    rom_entry = 16'h1418;
      4'd9:    rom_entry = 16'h8C00;
      default: rom_entry = 16'hFFFF;
    endcase
  endfunction

  state_t            state;
  logic [3:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        phase;
  logic [4:0]        bit_cnt;
  logic [26:0]       shreg;
  logic              start_q;
  logic [15:0]       entry;
  logic              start_rise;
  logic              cnt_tc;

  assign entry      = rom_entry(idx);
  assign start_rise = i_start & ~start_q;
  assign cnt_tc     = (cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      start_q <= 1'b0;
      o_done  <= 1'b0;
      o_scl   <= 1'b1;
      o_sda   <= 1'b1;
    end else begin
      start_q <= i_start;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            state <= S_LOAD;
            idx   <= '0;
          end
        end

        S_LOAD: begin
          if (entry == ENT_END) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else if (entry == ENT_WAIT) begin
            state <= S_DELAY;
            cnt   <= DLY_LD;
          end else if (i_scl && i_sda) begin
            // only open a START onto a bus that actually reads idle
            state <= S_START;
            o_sda <= 1'b0;
            cnt   <= Q_LD;
            shreg <= {DEV_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
          end
        end

        S_START: begin
          if (cnt_tc) begin
            state   <= S_BITS;
            phase   <= 2'd0;
            bit_cnt <= '0;
            o_scl   <= 1'b0;
            cnt     <= Q_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_BITS: begin
          // SDA follows one cycle after SCL fell, so it never moves near the edge
          if (phase == 2'd0) o_sda <= shreg[26];
          if (!(phase == 2'd2 && !i_scl)) begin
            if (!cnt_tc) begin
              cnt <= cnt - 1'b1;
            end else begin
              cnt   <= Q_LD;
              phase <= phase + 2'd1;
              case (phase)
                2'd1: o_scl <= 1'b1;
                2'd3: begin
                  o_scl <= 1'b0;
                  if (bit_cnt == 5'd26) begin
                    state <= S_STOP;
                    phase <= 2'd0;
                  end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                    shreg   <= {shreg[25:0], 1'b0};
                  end
                end
                default: ;
              endcase
            end
          end
        end

        S_STOP: begin
          if (phase == 2'd0) begin
            o_sda <= 1'b0;
            if (cnt_tc) begin
              phase <= 2'd1;
              o_scl <= 1'b1;
              cnt   <= Q_LD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else if (i_scl) begin
            if (cnt_tc) begin
              o_sda <= 1'b1;
              state <= S_GAP;
              cnt   <= GAP_LD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        S_GAP, S_DELAY: begin
          if (cnt_tc) begin
            state <= S_LOAD;
            idx   <= idx + 4'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DONE: begin
          if (start_rise) begin
            o_done <= 1'b0;
            state  <= S_LOAD;
            idx    <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_cfg_interface.sv
// Bench for camera_cfg_interface: a fast-timing instance runs the full table,
// a default-timing instance checks the first write at real SCL timing.
module tb_camera_cfg_interface;

  localparam int S_T  = 1000;
  localparam int S_K  = 100;
  localparam int QS   = (250000 + S_K * S_T - 1) / (S_K * S_T);
  localparam int DLYS = (10000000 + S_T - 1) / S_T;
  localparam int QD   = (250000 + 100 * 13 - 1) / (100 * 13);

  logic clk;
  logic rst_s, rst_d, start_s, start_d;
  logic s_done, s_o_scl, s_o_sda, s_i_scl, s_i_sda;
  logic d_done, d_o_scl, d_o_sda, d_i_scl, d_i_sda;
  logic hold;

  assign s_i_scl = s_o_scl & ~hold;
  assign s_i_sda = s_o_sda;
  assign d_i_scl = d_o_scl;
  assign d_i_sda = d_o_sda;

  camera_cfg_interface #(.T_CLK(S_T), .SCL_KHZ(S_K), .DEV_ADDR(8'h42)) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_start(start_s), .o_done(s_done),
    .i_scl(s_i_scl), .i_sda(s_i_sda), .o_scl(s_o_scl), .o_sda(s_o_sda)
  );

  camera_cfg_interface dut_d (
    .i_clk(clk), .i_rst(rst_d), .i_start(start_d), .o_done(d_done),
    .i_scl(d_i_scl), .i_sda(d_i_sda), .o_scl(d_o_scl), .o_sda(d_o_sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Bus decoder: START/STOP conditions, bits sampled on SCL rise.
  int          bits      [2] = '{0, 0};
  logic [26:0] sh        [2];
  bit          in_frame  [2] = '{0, 0};
  logic        prev_scl  [2] = '{1'b1, 1'b1};
  logic        prev_sda  [2] = '{1'b1, 1'b1};
  int          tx_cnt    [2] = '{0, 0};
  logic [23:0] tx_log    [2][16];
  int          frame_err [2] = '{0, 0};
  int          ack_err   [2] = '{0, 0};
  int          r0        [2] = '{0, 0};
  int          first_iv  [2] = '{-1, -1};
  int          last_stop [2] = '{0, 0};
  bit          stop_ok   [2] = '{0, 0};
  int          min_idle  [2] = '{1000000000, 1000000000};
  int          first_stop[2] = '{0, 0};
  bit          watch_gap [2] = '{0, 0};
  int          gap_first [2] = '{-1, -1};
  int          clr_req   [2] = '{0, 0};
  int          clr_seen  [2] = '{0, 0};
  bit          mute      [2] = '{0, 0};

  always @(negedge clk) begin
    logic scl_v, sda_v;
    for (int k = 0; k < 2; k++) begin
      scl_v = (k == 0) ? s_i_scl : d_i_scl;
      sda_v = (k == 0) ? s_i_sda : d_i_sda;
      if (clr_seen[k] != clr_req[k]) begin
        clr_seen[k] = clr_req[k];
        in_frame[k] = 0;
        bits[k]     = 0;
        stop_ok[k]  = 0;
      end
      if (!mute[k]) begin
        if (prev_scl[k] && scl_v && prev_sda[k] && !sda_v) begin
          if (in_frame[k]) frame_err[k]++;
          if (stop_ok[k] && (cyc - last_stop[k]) < min_idle[k]) min_idle[k] = cyc - last_stop[k];
          in_frame[k] = 1;
          bits[k]     = 0;
        end else if (prev_scl[k] && scl_v && !prev_sda[k] && sda_v) begin
          if (!in_frame[k] || bits[k] != 28) frame_err[k]++;
          else begin
            if (!(sh[k][18] && sh[k][9] && sh[k][0])) ack_err[k]++;
            if (tx_cnt[k] < 16) tx_log[k][tx_cnt[k]] = {sh[k][26:19], sh[k][17:10], sh[k][8:1]};
            if (tx_cnt[k] == 0) begin
              first_stop[k] = cyc;
              watch_gap[k]  = 1;
            end
            tx_cnt[k]++;
          end
          in_frame[k]  = 0;
          last_stop[k] = cyc;
          stop_ok[k]   = 1;
        end else if (!prev_scl[k] && scl_v && in_frame[k]) begin
          if (bits[k] < 27) sh[k] = {sh[k][25:0], sda_v};
          if (tx_cnt[k] == 0 && bits[k] == 0) r0[k] = cyc;
          if (tx_cnt[k] == 0 && bits[k] == 1) first_iv[k] = cyc - r0[k];
          bits[k]++;
        end
        if (scl_v != prev_scl[k] && watch_gap[k]) begin
          gap_first[k] = cyc - first_stop[k];
          watch_gap[k] = 0;
        end
      end
      prev_scl[k] = scl_v;
      prev_sda[k] = sda_v;
    end
  end

  // Slave clock stretch: hold SCL low for 1000 cycles on bit 3 of the first write.
  bit  arm = 0;
  int  hi_dur = -1;
  int  rises = 0;
  time t0;
  initial begin
    hold = 1'b0;
    wait (arm);
    while (rises < 3) begin
      @(posedge s_o_scl);
      rises++;
    end
    @(posedge s_o_scl);
    t0   = $time;
    hold = 1'b1;
    repeat (1000) @(posedge clk);
    #1 hold = 1'b0;
    @(negedge s_o_scl);
    hi_dur = int'(($time - t0) / 10);
  end

  logic [15:0] rom_tbl [11];
  logic [23:0] exp_tx [$];

  initial begin
    int n;
    int base;
    int nsel;
    rom_tbl = '{16'h1280, 16'hFFF0, 16'h1204, 16'h1180, 16'h0C00, 16'h3E00,
                16'h40D0, 16'h3A04, 16'h1418, 16'h8C00, 16'hFFFF};
    for (int i = 0; i < 11; i++) begin
      if (rom_tbl[i] == 16'hFFFF) break;
      if (rom_tbl[i] != 16'hFFF0) exp_tx.push_back({8'h42, rom_tbl[i]});
    end

    rst_s = 1'b1; rst_d = 1'b1; start_s = 1'b0; start_d = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_done_s", int'(s_done), 0);
    chk("rst_scl_s",  int'(s_o_scl), 1);
    chk("rst_sda_s",  int'(s_o_sda), 1);
    chk("rst_done_d", int'(d_done), 0);
    chk("rst_scl_d",  int'(d_o_scl), 1);
    chk("rst_sda_d",  int'(d_o_sda), 1);
    rst_s = 1'b0; rst_d = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_lines_s", int'({s_o_scl, s_o_sda, s_done}), 6);
    chk("idle_lines_d", int'({d_o_scl, d_o_sda, d_done}), 6);

    arm = 1;
    repeat ($urandom_range(1, 8)) @(negedge clk);
    start_s = 1'b1; start_d = 1'b1;

    n = 0;
    while (tx_cnt[0] < 1 && n < 3000) begin @(negedge clk); n++; end
    chk("first_write_seen", int'(tx_cnt[0] >= 1), 1);
    repeat ($urandom_range(10, 500)) @(negedge clk);
    start_s = 1'b0;
    repeat (2) @(negedge clk);
    start_s = 1'b1;

    n = 0;
    while (!s_done && n < 30000) begin @(negedge clk); n++; end
    chk("run1_done", int'(s_done), 1);
    chk("run1_tx_count", tx_cnt[0], exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      chk($sformatf("run1_tx%0d", i), int'(tx_log[0][i]), int'(exp_tx[i]));
    chk("frame_err_s", frame_err[0], 0);
    chk("ack_released_s", ack_err[0], 0);
    chk("scl_period_s", first_iv[0], 4 * QS);
    chk_range("stop_to_next_scl", gap_first[0], DLYS, DLYS + 6 * QS + 10);
    chk_range("min_bus_idle", min_idle[0], 4 * QS, 4 * QS + 3);
    chk("stretch_high", hi_dur, 2 * QS + 1000);

    repeat (200) @(negedge clk);
    chk("done_held", int'(s_done), 1);
    chk("no_restart_level", tx_cnt[0], exp_tx.size());
    chk("done_lines", int'({s_o_scl, s_o_sda}), 3);

    start_s = 1'b0;
    repeat (3) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    chk("restart_clears_done", int'(s_done), 0);

    base = tx_cnt[0];
    nsel = $urandom_range(19, 26);
    n = 0;
    while (!(in_frame[0] && bits[0] >= nsel) && n < 2000) begin @(negedge clk); n++; end
    chk("reached_third_byte", int'(in_frame[0] && bits[0] >= nsel), 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    mute[0] = 1;
    rst_s   = 1'b1;
    @(negedge clk);
    chk("rst_mid_scl", int'(s_o_scl), 1);
    chk("rst_mid_sda", int'(s_o_sda), 1);
    chk("rst_mid_done", int'(s_done), 0);
    rst_s = 1'b0; start_s = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", int'({s_o_scl, s_o_sda}), 3);
    chk("aborted_not_logged", tx_cnt[0], base);
    clr_req[0]++;
    @(negedge clk);
    mute[0] = 0;
    start_s = 1'b1;
    n = 0;
    while (tx_cnt[0] < base + 1 && n < 2000) begin @(negedge clk); n++; end
    chk("replay_count", tx_cnt[0], base + 1);
    chk("replay_tx0", int'(tx_log[0][base]), int'(exp_tx[0]));

    repeat ($urandom_range(20, 200)) @(negedge clk);
    mute[0] = 1;
    rst_s   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wins_start_high", int'({s_o_scl, s_o_sda, s_done}), 6);
    clr_req[0]++;
    mute[0] = 0;
    @(negedge clk);
    rst_s = 1'b0;
    n = 0;
    while (s_o_sda && n < QS + 10) begin @(negedge clk); n++; end
    chk("level_after_rst_starts", int'(s_o_sda), 0);
    n = 0;
    while (tx_cnt[0] < base + 2 && n < 2000) begin @(negedge clk); n++; end
    chk("level_restart_count", tx_cnt[0], base + 2);
    chk("level_restart_tx0", int'(tx_log[0][base + 1]), int'(exp_tx[0]));

    n = 0;
    while (tx_cnt[1] < 1 && n < 40000) begin @(negedge clk); n++; end
    chk("default_tx_count", tx_cnt[1], 1);
    chk("default_tx0", int'(tx_log[1][0]), int'(exp_tx[0]));
    chk("default_scl_period", first_iv[1], 4 * QD);
    chk("frame_err_d", frame_err[1], 0);
    chk("ack_released_d", ack_err[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_cfg_interface.md
CAMERA_CFG_INTERFACE -- requirements
Module: camera_cfg_interface

Interface
REQ-001 Parameter T_CLK, default 13, i_clk period in ns; all timing counts derive from it.
REQ-002 Parameter SCL_KHZ, default 100, target SCL frequency in kHz.
REQ-003 Parameter DEV_ADDR, default 8'h42, 8-bit SCCB write address (OV7670).
REQ-004 i_clk  input  1  single system clock, nominal 75 MHz, all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_start  input  1  rising edge starts one full configuration sequence.
REQ-007 o_done  output  1  high when the sequence has completed.
REQ-008 i_scl  input  1  sampled SCL bus level, after the external pull-up.
REQ-009 i_sda  input  1  sampled SDA bus level, after the external pull-up.
REQ-010 o_scl  output  1  open-drain SCL control: 1 = release (Z), 0 = drive low.
REQ-011 o_sda  output  1  open-drain SDA control: 1 = release (Z), 0 = drive low.

Function
REQ-012 Quarter-bit count Q SHALL be ceil(250000/(SCL_KHZ*T_CLK)) cycles; Q = 193 at the defaults.
REQ-013 Internal ROM SHALL hold 16-bit entries {reg,val}, read sequentially from index 0.
REQ-014 Mandatory ROM table, in order: 1280, FFF0, 1204, 1180, 0C00, 3E00, 40D0, 3A04, 1418, 8C00, FFFF.
REQ-015 Entry FFFF SHALL mark end of table; entry FFF0 SHALL mean a 10 ms wait, with no bus activity, of ceil(10_000_000/T_CLK) cycles.
REQ-016 Every other entry SHALL produce one 3-phase SCCB write: START, DEV_ADDR, reg, val, STOP.
REQ-017 Each byte SHALL be sent MSB first, followed by a 9th (ACK) bit with SDA released; ACK/NACK SHALL be ignored.
REQ-018 Each bit SHALL take 4Q cycles:
- Q1: SCL low, SDA set to the bit value.
- Q2: SCL low.
- Q3: SCL released.
- Q4: SCL released.
- SDA SHALL change only while SCL is low.
REQ-019 START: SDA falls while SCL is released, holding Q cycles before SCL goes low.
REQ-020 STOP: SDA low, SCL released, then after Q cycles SDA released.
REQ-021 Bus idle of at least 4Q cycles SHALL separate consecutive transactions.
REQ-022 Clock stretching: on entering a Q3 phase, the Q counter SHALL hold until i_scl reads 1.
REQ-023 FSM states and transitions:
- IDLE -> LOAD on i_start rising edge.
- LOAD -> DONE on FFFF; LOAD -> DELAY on FFF0; LOAD -> START otherwise.
- START -> BITS (27 bits) -> STOP -> GAP -> LOAD with index+1.
- DELAY -> LOAD with index+1.
- DONE: o_done=1, lines released.
REQ-024 i_start SHALL be edge-detected against its registered previous value; a level held high SHALL not restart.
REQ-025 An i_start rising edge while busy SHALL be ignored.
REQ-026 In DONE, an i_start rising edge SHALL clear o_done and restart from index 0.
REQ-027 o_scl and o_sda SHALL be registered outputs, free of glitches.

Reset
REQ-028 i_rst=1 SHALL force:
- state IDLE, ROM index 0, counters 0;
- o_done=0, o_scl=1, o_sda=1;
- start-edge register 0.
REQ-029 Reset SHALL win over all other events in the same cycle.
REQ-030 Reset asserted mid-transaction SHALL release both lines on the next edge, with no STOP generated.
REQ-031 After reset, a start level already high SHALL count as a rising edge.

Verification
REQ-032 Reset held 5 cycles -> o_done=0, o_scl=1, o_sda=1; with i_start=0 the lines stay released.
REQ-033 i_start 0->1 at T_CLK=13 -> START, then bytes 0x42, 0x12, 0x80 on SDA sampled at SCL rise, 9th bit released, SCL period 772 cycles.
REQ-034 After the first STOP -> no SCL edge for at least 769231 cycles, then the second write 0x42, 0x12, 0x04.
REQ-035 Full run -> exactly 9 write transactions, then o_done=1 held while i_start stays high.
REQ-036 Slave holds SCL low 1000 cycles during bit 3 -> that bit's high phase extends by 1000 cycles, data unchanged.
REQ-037 i_rst pulse during the third byte -> o_scl=o_sda=1 next cycle; a new i_start edge replays from entry 0.
